// File: rtl/red_pitaya_asg_slew.sv
// red_pitaya_asg_slew: slew-rate limiter and soft-off stage for one ASG channel.
//
// Ports:
//   dac_clk_i   DAC clock; all logic on its rising edge
//   dac_rstn_i  asynchronous active-low reset
//   dat_i       signed target sample from the channel
//   set_step_i  unsigned maximum change per tick (0 = unlimited)
//   set_div_i   tick period minus one, in clock cycles
//   set_en_i    1 = slew limiting active, 0 = bypass
//   set_off_i   soft-off request (level)
//   dat_o       signed conditioned sample to the DAC (registered)
//   busy_o      output still ramping toward its target (registered)
//   off_o       high while held at zero in the OFF state (registered)
module red_pitaya_asg_slew #(
    parameter int unsigned DW   = 14,
    parameter int unsigned DIVW = 16
) (
    input  logic            dac_clk_i,
    input  logic            dac_rstn_i,
    input  logic [DW-1:0]   dat_i,
    input  logic [DW-1:0]   set_step_i,
    input  logic [DIVW-1:0] set_div_i,
    input  logic            set_en_i,
    input  logic            set_off_i,
    output logic [DW-1:0]   dat_o,
    output logic            busy_o,
    output logic            off_o
);

    // One guard bit so the error and the stepped value never overflow.
    localparam int unsigned EW = DW + 1;

    typedef enum logic [1:0] {
        ST_BYPASS   = 2'd0,
        ST_TRACK    = 2'd1,
        ST_RAMPDOWN = 2'd2,
        ST_OFF      = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_cnt_nxt;
    logic [DW-1:0]   dat_nxt;
    logic            busy_nxt;
    logic            off_nxt;

    logic            ramping;
    logic            ramping_nxt;
    logic            tick;
    logic [DW-1:0]   target;
    logic [DW-1:0]   target_nxt;
    logic [EW-1:0]   err;
    logic [EW-1:0]   err_abs;
    logic [EW-1:0]   step_ext;
    logic [EW-1:0]   stepped;
    logic [DW-1:0]   slew_dat;

    // Tick generation and one slew step toward the current target.
    assign ramping  = (state == ST_TRACK) || (state == ST_RAMPDOWN);
    assign tick     = ramping && (div_cnt >= set_div_i);
    assign target   = (state == ST_RAMPDOWN) ? '0 : dat_i;
    assign err      = {target[DW-1], target} - {dat_o[DW-1], dat_o};
    assign err_abs  = err[EW-1] ? (~err + EW'(1)) : err;
    assign step_ext = {1'b0, set_step_i};
    assign stepped  = err[EW-1] ? ({dat_o[DW-1], dat_o} - step_ext)
                                : ({dat_o[DW-1], dat_o} + step_ext);
    // The stepped value always lies between dat_o and target, so dropping the
    // guard bit is lossless.
    assign slew_dat = ((set_step_i == '0) || (err_abs <= step_ext)) ? target
                                                                     : stepped[DW-1:0];

    // State register and registered outputs.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state   <= ST_BYPASS;
            div_cnt <= '0;
            dat_o   <= '0;
            busy_o  <= 1'b0;
            off_o   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            dat_o   <= dat_nxt;
            busy_o  <= busy_nxt;
            off_o   <= off_nxt;
        end
    end

    // Next-state logic; a soft-off request always wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BYPASS: begin
                if (set_off_i)     state_nxt = ST_RAMPDOWN;
                else if (set_en_i) state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (set_off_i)      state_nxt = ST_RAMPDOWN;
                else if (!set_en_i) state_nxt = ST_BYPASS;
            end
            ST_RAMPDOWN: begin
                if (!set_off_i)         state_nxt = set_en_i ? ST_TRACK : ST_BYPASS;
                else if (dat_o == '0)   state_nxt = ST_OFF;
            end
            ST_OFF: begin
                if (!set_off_i) state_nxt = set_en_i ? ST_TRACK : ST_BYPASS;
            end
            default: state_nxt = ST_BYPASS;
        endcase
    end

    // Output logic: current-state datapath action plus next-cycle flags.
    always_comb begin
        dat_nxt     = dat_o;
        div_cnt_nxt = '0;
        case (state)
            ST_BYPASS:   dat_nxt = dat_i;
            ST_TRACK,
            ST_RAMPDOWN: if (tick) dat_nxt = slew_dat;
            ST_OFF:      dat_nxt = '0;
            default:     dat_nxt = '0;
        endcase

        ramping_nxt = (state_nxt == ST_TRACK) || (state_nxt == ST_RAMPDOWN);
        // Divider restarts on every entry so the first tick is a full period away.
        if (ramping_nxt && (state_nxt == state))
            div_cnt_nxt = tick ? '0 : div_cnt + DIVW'(1);

        target_nxt = (state_nxt == ST_RAMPDOWN) ? '0 : dat_i;
        busy_nxt   = ramping_nxt && (dat_nxt != target_nxt);
        off_nxt    = (state_nxt == ST_OFF);
    end

endmodule

// File: tb/tb_red_pitaya_asg_slew.sv
// tb_red_pitaya_asg_slew: directed self-checking bench for red_pitaya_asg_slew.
module tb_red_pitaya_asg_slew;

    logic        clk;
    logic        rst_n;
    logic [13:0] dat_i;
    logic [13:0] set_step;
    logic [15:0] set_div;
    logic        set_en;
    logic        set_off;
    logic [13:0] dat_o;
    logic        busy;
    logic        off;

    int errors = 0;
    int checks = 0;

    red_pitaya_asg_slew #(.DW(14), .DIVW(16)) dut (
        .dac_clk_i  (clk),
        .dac_rstn_i (rst_n),
        .dat_i      (dat_i),
        .set_step_i (set_step),
        .set_div_i  (set_div),
        .set_en_i   (set_en),
        .set_off_i  (set_off),
        .dat_o      (dat_o),
        .busy_o     (busy),
        .off_o      (off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        dat_i    = 14'(1000);
        set_step = '0;
        set_div  = '0;
        set_en   = 1'b0;
        set_off  = 1'b0;
        #12;
        checks++; if (dat_o !== 14'd0) begin errors++; $display("FAIL reset_dat: got %0d want 0", $signed(dat_o)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (off !== 1'b0) begin errors++; $display("FAIL reset_off: got %b want 0", off); end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++; if (dat_o !== 14'(1000)) begin errors++; $display("FAIL bypass_dat: got %0d want 1000", $signed(dat_o)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b want 0", busy); end
    endtask

    task automatic test_track_up();
        dat_i = '0;
        cyc();
        set_en = 1'b1;
        cyc();
        checks++; if (dat_o !== 14'd0) begin errors++; $display("FAIL track_entry: got %0d want 0", $signed(dat_o)); end
        set_step = 14'(100);
        set_div  = '0;
        dat_i    = 14'(1000);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (dat_o !== 14'(100 * k)) begin errors++; $display("FAIL track_up_dat[%0d]: got %0d want %0d", k, $signed(dat_o), 100 * k); end
            checks++;
            if (busy !== (k < 10)) begin errors++; $display("FAIL track_up_busy[%0d]: got %b want %b", k, busy, (k < 10)); end
        end
    endtask

    task automatic test_track_down_div();
        int cur;
        int nxt;
        int expv;
        set_en = 1'b0;
        dat_i  = 14'(50);
        cyc();
        cyc();
        checks++; if (dat_o !== 14'(50)) begin errors++; $display("FAIL prep50: got %0d want 50", $signed(dat_o)); end
        set_en = 1'b1;
        cyc();
        set_div = 16'd3;
        dat_i   = 14'(-8192);
        cur = 50;
        for (int t = 1; t <= 83; t++) begin
            nxt = (cur - 100 < -8192) ? -8192 : cur - 100;
            for (int c = 1; c <= 4; c++) begin
                cyc();
                expv = (c < 4) ? cur : nxt;
                checks++;
                if (dat_o !== 14'(expv)) begin errors++; $display("FAIL div_dat[%0d.%0d]: got %0d want %0d", t, c, $signed(dat_o), expv); end
                checks++;
                if (busy !== ((c < 4) || (nxt != -8192))) begin errors++; $display("FAIL div_busy[%0d.%0d]: got %b", t, c, busy); end
            end
            cur = nxt;
        end
        for (int c = 0; c < 6; c++) begin
            cyc();
            checks++;
            if (dat_o !== 14'h2000) begin errors++; $display("FAIL div_hold: got %0d want -8192", $signed(dat_o)); end
        end
    endtask

    task automatic test_full_swing();
        set_en = 1'b0;
        dat_i  = 14'(8191);
        cyc();
        cyc();
        checks++; if (dat_o !== 14'h1FFF) begin errors++; $display("FAIL prep8191: got %0d want 8191", $signed(dat_o)); end
        set_en   = 1'b1;
        set_step = '0;
        set_div  = '0;
        cyc();
        dat_i = 14'(-8192);
        cyc();
        checks++; if (dat_o !== 14'h2000) begin errors++; $display("FAIL swing_dat: got %0d want -8192", $signed(dat_o)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swing_busy: got %b want 0", busy); end
    endtask

    task automatic test_soft_off();
        int down [4] = '{250, 150, 50, 0};
        int up   [4] = '{100, 200, 300, 350};
        dat_i = 14'(350);
        cyc();
        checks++; if (dat_o !== 14'(350)) begin errors++; $display("FAIL prep350: got %0d want 350", $signed(dat_o)); end
        set_step = 14'(100);
        set_off  = 1'b1;
        cyc();
        checks++; if (dat_o !== 14'(350) || busy !== 1'b1 || off !== 1'b0) begin
            errors++; $display("FAIL rd_entry: got dat=%0d busy=%b off=%b want 350/1/0", $signed(dat_o), busy, off); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (dat_o !== 14'(down[i]) || busy !== (i < 3) || off !== 1'b0) begin
                errors++; $display("FAIL rd_step[%0d]: got dat=%0d busy=%b off=%b want %0d", i, $signed(dat_o), busy, off, down[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (off !== 1'b1 || dat_o !== 14'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL off_hold[%0d]: got dat=%0d busy=%b off=%b want 0/0/1", i, $signed(dat_o), busy, off); end
        end
        set_off = 1'b0;
        cyc();
        checks++; if (off !== 1'b0 || dat_o !== 14'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL off_release: got dat=%0d busy=%b off=%b want 0/1/0", $signed(dat_o), busy, off); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (dat_o !== 14'(up[i]) || busy !== (i < 3)) begin
                errors++; $display("FAIL ramp_up[%0d]: got dat=%0d busy=%b want %0d", i, $signed(dat_o), busy, up[i]); end
        end
    endtask

    task automatic test_release_bypass();
        set_off = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++; if (dat_o !== 14'(150)) begin errors++; $display("FAIL rd150: got %0d want 150", $signed(dat_o)); end
        set_off = 1'b0;
        set_en  = 1'b0;
        dat_i   = 14'(777);
        cyc();
        checks++; if (busy !== 1'b0 || off !== 1'b0) begin errors++; $display("FAIL rel_flags: got busy=%b off=%b want 0/0", busy, off); end
        cyc();
        checks++; if (dat_o !== 14'(777)) begin errors++; $display("FAIL rel_bypass: got %0d want 777", $signed(dat_o)); end
    endtask

    task automatic test_reset_mid_ramp();
        set_en = 1'b1;
        cyc();
        dat_i = 14'(-2000);
        cyc();
        cyc();
        checks++; if (dat_o !== 14'(577) || busy !== 1'b1) begin errors++; $display("FAIL pre_rst: got dat=%0d busy=%b want 577/1", $signed(dat_o), busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dat_o !== 14'd0 || busy !== 1'b0 || off !== 1'b0) begin
            errors++; $display("FAIL async_rst: got dat=%0d busy=%b off=%b want 0/0/0", $signed(dat_o), busy, off); end
        cyc();
        checks++; if (dat_o !== 14'd0) begin errors++; $display("FAIL rst_hold: got %0d want 0", $signed(dat_o)); end
        rst_n = 1'b1;
        cyc();
        checks++; if (dat_o !== 14'h3830) begin errors++; $display("FAIL post_rst: got %0d want -2000", $signed(dat_o)); end
    endtask

    initial begin
        test_reset();
        test_track_up();
        test_track_down_div();
        test_full_swing();
        test_soft_off();
        test_release_bypass();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
